// File: rtl/tcdm_tgen_pkg.sv
// Shared types and helpers for the TCDM traffic generator.
// Contents: address mode enum, FSM state encoding, LFSR polynomial,
// LFSR step function and saturating increment.
package tcdm_tgen_pkg;

  typedef enum logic [1:0] {
    MODE_UNIFORM = 2'd0,
    MODE_LINEAR  = 2'd1,
    MODE_STRIDED = 2'd2
  } mode_e;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  // Galois polynomial x^32+x^22+x^2+x+1
  localparam logic [31:0] LfsrPoly = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LfsrPoly : 32'd0);
  endfunction

  // Counter widths up to 64 bits; max is the all-ones value of the real width.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max);
    sat_inc = (val == max) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/tcdm_tgen_chan.sv
// One traffic generator channel: LFSR, request/hold registers, response-valid
// check and saturating statistics counters.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   clr_i                 run start: clear stats and linear address
//   run_i                 FSM in RUN (LFSR advances)
//   issue_i               a draw may be made this cycle
//   chk_i                 response check active
//   mode_i, req_prob_i, wr_prob_i, stride_i   run configuration
//   gnt_i, rvld_i         TCDM grant / response valid
//   req_o, wen_o, add_o, wdata_o, be_o        TCDM request fields
//   *_cnt_o               statistics
module tcdm_tgen_chan
  import tcdm_tgen_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrBits  = 19,
  parameter int unsigned CntWidth  = 32,
  parameter logic [31:0] Seed      = 32'hACE1_2344
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   run_i,
  input  logic                   issue_i,
  input  logic                   chk_i,
  input  logic [1:0]             mode_i,
  input  logic [8:0]             req_prob_i,
  input  logic [8:0]             wr_prob_i,
  input  logic [AddrWidth-1:0]   stride_i,
  input  logic                   gnt_i,
  input  logic                   rvld_i,
  output logic                   req_o,
  output logic                   wen_o,
  output logic [AddrWidth-1:0]   add_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic [DataWidth/8-1:0] be_o,
  output logic [CntWidth-1:0]    req_cnt_o,
  output logic [CntWidth-1:0]    gnt_cnt_o,
  output logic [CntWidth-1:0]    wait_cnt_o,
  output logic [CntWidth-1:0]    err_cnt_o
);

  localparam int unsigned WordBytes = DataWidth / 8;
  localparam int unsigned Reps      = (DataWidth + 31) / 32;
  localparam logic [AddrWidth-1:0] AddrMask  = {AddrWidth{1'b1}} >> (AddrWidth - AddrBits);
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(WordBytes - 1);
  localparam logic [63:0]          CntMax    = {64{1'b1}} >> (64 - CntWidth);

  logic [31:0]            lfsr_q;
  logic                   req_q, wen_q, exp_q;
  logic [AddrWidth-1:0]   add_q, lin_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [WordBytes-1:0]   be_q;
  logic [CntWidth-1:0]    req_cnt_q, gnt_cnt_q, wait_cnt_q, err_cnt_q;

  logic                   free, draw, issue, err_ev;
  logic [AddrWidth-1:0]   addr_new, step;
  logic [Reps*32-1:0]     lfsr_rep;

  assign lfsr_rep = {Reps{lfsr_q}};
  assign free     = ~req_q | gnt_i;
  assign draw     = issue_i & free;
  assign issue    = draw & ({1'b0, lfsr_q[7:0]} < req_prob_i);
  // A grant one cycle ago must be answered now, and nothing else may answer.
  assign err_ev   = chk_i & (exp_q ^ rvld_i);

  always_comb begin
    addr_new = lin_q;
    step     = AddrWidth'(WordBytes);
    case (mode_i)
      MODE_UNIFORM: addr_new = AddrWidth'(lfsr_q);
      MODE_STRIDED: step     = stride_i;
      default:      ;  // linear (mode 3 included)
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q     <= Seed;
      req_q      <= 1'b0;
      wen_q      <= 1'b0;
      add_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lin_q      <= '0;
      exp_q      <= 1'b0;
      req_cnt_q  <= '0;
      gnt_cnt_q  <= '0;
      wait_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (run_i) lfsr_q <= lfsr_next(lfsr_q);

      if (clr_i) begin
        lin_q <= '0;
      end else if (issue) begin
        lin_q <= (lin_q + step) & AddrMask & AlignMask;
      end

      if (draw) begin
        req_q <= issue;
      end else if (gnt_i) begin
        req_q <= 1'b0;
      end

      if (issue) begin
        wen_q   <= ({1'b0, lfsr_q[15:8]} < wr_prob_i);
        add_q   <= addr_new & AddrMask & AlignMask;
        wdata_q <= lfsr_rep[DataWidth-1:0];
        be_q    <= '1;
      end

      exp_q <= req_q & gnt_i;

      if (clr_i) begin
        req_cnt_q  <= '0;
        gnt_cnt_q  <= '0;
        wait_cnt_q <= '0;
        err_cnt_q  <= '0;
      end else begin
        if (issue)          req_cnt_q  <= CntWidth'(sat_inc(64'(req_cnt_q), CntMax));
        if (req_q & gnt_i)  gnt_cnt_q  <= CntWidth'(sat_inc(64'(gnt_cnt_q), CntMax));
        if (req_q & ~gnt_i) wait_cnt_q <= CntWidth'(sat_inc(64'(wait_cnt_q), CntMax));
        if (err_ev)         err_cnt_q  <= CntWidth'(sat_inc(64'(err_cnt_q), CntMax));
      end
    end
  end

  assign req_o      = req_q;
  assign wen_o      = wen_q;
  assign add_o      = add_q;
  assign wdata_o    = wdata_q;
  assign be_o       = be_q;
  assign req_cnt_o  = req_cnt_q;
  assign gnt_cnt_o  = gnt_cnt_q;
  assign wait_cnt_o = wait_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/tcdm_traffic_gen.sv
// TCDM traffic generator and statistics monitor (master side of tcdm_interconnect).
// Holds the run FSM (IDLE -> RUN -> DRAIN -> DONE) and the issue-cycle counter;
// per-master request generation and statistics live in tcdm_tgen_chan.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   start_i, mode_i, cycles_i        run control (sampled in IDLE)
//   req_prob_i, wr_prob_i, stride_i  traffic shape
//   busy_o, done_o                   run status
//   req_o, wen_o, add_o, wdata_o, be_o, gnt_i, rvld_i, rdata_i   TCDM master ports
//   req_cnt_o, gnt_cnt_o, wait_cnt_o, err_cnt_o                 statistics
module tcdm_traffic_gen
  import tcdm_tgen_pkg::*;
#(
  parameter int unsigned NumMaster = 16,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrBits  = 19,
  parameter int unsigned CntWidth  = 32,
  parameter logic [31:0] LfsrSeed  = 32'hACE1_2345
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic [1:0]                            mode_i,
  input  logic [CntWidth-1:0]                   cycles_i,
  input  logic [8:0]                            req_prob_i,
  input  logic [8:0]                            wr_prob_i,
  input  logic [AddrWidth-1:0]                  stride_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [NumMaster-1:0]                  req_o,
  output logic [NumMaster-1:0]                  wen_o,
  output logic [NumMaster-1:0][AddrWidth-1:0]   add_o,
  output logic [NumMaster-1:0][DataWidth-1:0]   wdata_o,
  output logic [NumMaster-1:0][DataWidth/8-1:0] be_o,
  input  logic [NumMaster-1:0]                  gnt_i,
  input  logic [NumMaster-1:0]                  rvld_i,
  input  logic [NumMaster-1:0][DataWidth-1:0]   rdata_i,
  output logic [NumMaster-1:0][CntWidth-1:0]    req_cnt_o,
  output logic [NumMaster-1:0][CntWidth-1:0]    gnt_cnt_o,
  output logic [NumMaster-1:0][CntWidth-1:0]    wait_cnt_o,
  output logic [NumMaster-1:0][CntWidth-1:0]    err_cnt_o
);

  state_t              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [1:0]          mode_q;
  logic                start_run, in_run, issue_en, chk_en;
  logic                unused_rdata;

  assign unused_rdata = ^rdata_i;

  assign start_run = (state_q == StIdle) & start_i;
  assign in_run    = (state_q == StRun);
  // cnt_q == 0 only for a zero-length run: one RUN cycle without a draw.
  assign issue_en  = in_run & (cnt_q != '0);
  assign chk_en    = in_run | (state_q == StDrain);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          cnt_d   = cycles_i;
        end
      end
      StRun: begin
        if ((cnt_q >> 1) == '0) state_d = StDrain;
        if (cnt_q != '0)        cnt_d   = cnt_q - 1'b1;
      end
      // With no request left, the only outstanding response is the one checked
      // this cycle, so DONE can follow immediately.
      StDrain: if (~|req_o) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_run) mode_q <= mode_i;
    end
  end

  assign busy_o = chk_en;
  assign done_o = (state_q == StDone);

  for (genvar m = 0; m < NumMaster; m++) begin : g_chan
    tcdm_tgen_chan #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .AddrBits  (AddrBits),
      .CntWidth  (CntWidth),
      .Seed      (LfsrSeed ^ 32'(m + 1))
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (start_run),
      .run_i      (in_run),
      .issue_i    (issue_en),
      .chk_i      (chk_en),
      .mode_i     (mode_q),
      .req_prob_i (req_prob_i),
      .wr_prob_i  (wr_prob_i),
      .stride_i   (stride_i),
      .gnt_i      (gnt_i[m]),
      .rvld_i     (rvld_i[m]),
      .req_o      (req_o[m]),
      .wen_o      (wen_o[m]),
      .add_o      (add_o[m]),
      .wdata_o    (wdata_o[m]),
      .be_o       (be_o[m]),
      .req_cnt_o  (req_cnt_o[m]),
      .gnt_cnt_o  (gnt_cnt_o[m]),
      .wait_cnt_o (wait_cnt_o[m]),
      .err_cnt_o  (err_cnt_o[m])
    );
  end

endmodule
